mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Arbitrates one unified single-port memory bus between the CPU's instruction-fetch port and its data-memory port. It sequences every transfer through a registered request/acknowledge handshake and stalls the losing or waiting requester. A bounded-starvation rule prevents instruction fetch from being locked out. A watchdog aborts hung transfers. It sits between the top-level core and the shared memory.

Parameters:
STARVE_MAX, 4, maximum consecutive data-port grants while a fetch is pending; must be >= 1.
TIMEOUT, 255, maximum cycles mem_req_o may wait for mem_ack_i before the transfer is aborted; must be >= 1.
CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous reset, active-high.
if_ce_i  in  1  instruction fetch request.
if_addr_i  in  32  fetch address.
if_data_o  out  32  fetched instruction, registered.
if_stall_o  out  1  fetch-port stall.
dm_ce_i  in  1  data access request.
dm_we_i  in  1  1 = write, 0 = read.
dm_sel_i  in  4  byte enables.
dm_addr_i  in  32  data address.
dm_wdata_i  in  32  write data.
dm_rdata_o  out  32  read data, registered.
dm_stall_o  out  1  data-port stall.
mem_req_o  out  1  memory request.
mem_we_o  out  1  memory write enable.
mem_sel_o  out  4  memory byte enables.
mem_addr_o  out  32  memory address.
mem_wdata_o  out  32  memory write data.
mem_rdata_i  in  32  memory read data; valid with mem_ack_i.
mem_ack_i  in  1  memory acknowledge.
bus_err_o  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset: all registered outputs are 0; FSM goes to IDLE; starvation and timeout counters are 0. Reset during a transfer drops mem_req_o at the next edge; the in-flight transfer is discarded.
- FSM states: IDLE, BUSY_IF, BUSY_DM, DONE.
- Grant in IDLE:
  - DM is granted if dm_ce_i=1 and (if_ce_i=0 or starve_cnt < STARVE_MAX).
  - Otherwise IF is granted if if_ce_i=1.
  - Otherwise the FSM stays in IDLE.
- On grant: at the same edge, latch the address, we, sel and wdata into the mem_* registers and set mem_req_o=1. For IF grants, mem_we_o=0, mem_sel_o=4'hF and mem_wdata_o=0.
- starve_cnt:
  - Increments on a DM grant while if_ce_i=1, saturating at STARVE_MAX.
  - Clears on an IF grant.
  - Clears on any IDLE cycle with if_ce_i=0.
- BUSY_x: mem_* outputs are held stable while mem_req_o=1. The first cycle with mem_ack_i=1 completes the transfer:
  - Clear mem_req_o.
  - For reads, register mem_rdata_i into if_data_o or dm_rdata_o.
  - For DM writes, dm_rdata_o is unchanged.
  - Go to DONE.
  - mem_ack_i while mem_req_o=0 is ignored.
- Timeout: the counter runs while in BUSY_x. When it reaches TIMEOUT with no ack:
  - Clear mem_req_o, pulse bus_err_o for 1 cycle, load 0 into the owner's data register, go to DONE.
  - An ack arriving in the same cycle takes precedence over the timeout.
- DONE: lasts one cycle with no new grant (the requester's ce_i still carries the completed request), then returns to IDLE.
- Stall:
  - if_stall_o = if_ce_i and not (state=DONE and owner=IF). dm_stall_o is defined the same way for DM.
  - Both are combinational from registered state plus ce_i.
  - A requester with ce_i=0 never sees stall.
- Latency: request seen in IDLE at cycle T → mem_req_o at T+1. Ack at cycle A (earliest T+1) → data valid and stall low at A+1. Minimum is 2 stall cycles per access.
- If the owner's ce_i drops mid-transfer, the transfer still completes; the result is registered and no stall is reported.
- Simultaneous ce_i with starve_cnt = STARVE_MAX → IF wins.

Test Plan:
- Reset values: rst=1 for 3 cycles with both ce_i high → all outputs 0, mem_req_o never asserted; after release, the first grant goes to DM.
- Single fetch: if_addr_i=0x00000004, if_ce_i=1 at T; ack with 0x3C011234 at T+1 → mem_req_o high T+1 only; if_data_o=0x3C011234 and if_stall_o=0 at T+2.
- Data write, then read: write 0xDEADBEEF, sel=4'b0011, to 0x10 → mem_we_o=1, mem_sel_o=0011, mem_wdata_o=0xDEADBEEF held until ack; dm_rdata_o unchanged. Following read of 0x10 returns the ack data.
- Starvation with STARVE_MAX=2: both ce_i held high, ack after 1 cycle each → grant order DM, DM, IF, DM, DM, IF; if_stall_o low exactly at each IF DONE.
- Timeout with TIMEOUT=5: DM read with no ack → mem_req_o high exactly 5 cycles; bus_err_o pulses once; dm_rdata_o=0; dm_stall_o low in DONE.
- Reset mid-transfer: rst asserted while in BUSY_IF → mem_req_o=0 next edge; a late ack after reset produces no data update and no DONE.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory bus between instruction fetch and data access,
// with bounded fetch starvation and a watchdog that aborts hung transfers.
module mem_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255,
    parameter int CNT_W      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_ce_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_stall_o,
    input  logic        dm_ce_i,
    input  logic        dm_we_i,
    input  logic [3:0]  dm_sel_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    output logic [31:0] dm_rdata_o,
    output logic        dm_stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_sel_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic        bus_err_o
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]    STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state_r;
    logic             owner_dm_r;
    logic [SW-1:0]    starve_cnt_r;
    logic [CNT_W-1:0] tmo_cnt_r;
    logic             grant_dm_s;
    logic             grant_if_s;
    logic             in_done_s;

    assign grant_dm_s = dm_ce_i && (!if_ce_i || (starve_cnt_r < STARVE_LIM));
    assign grant_if_s = !grant_dm_s && if_ce_i;
    assign in_done_s  = (state_r == DONE);

    // A requester is released only in the single DONE cycle of its own transfer.
    assign if_stall_o = if_ce_i && !(in_done_s && !owner_dm_r);
    assign dm_stall_o = dm_ce_i && !(in_done_s && owner_dm_r);

    // Arbitration FSM, bus registers, starvation and watchdog counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            owner_dm_r   <= 1'b0;
            starve_cnt_r <= '0;
            tmo_cnt_r    <= '0;
            mem_req_o    <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_sel_o    <= 4'h0;
            mem_addr_o   <= 32'h0;
            mem_wdata_o  <= 32'h0;
            if_data_o    <= 32'h0;
            dm_rdata_o   <= 32'h0;
            bus_err_o    <= 1'b0;
        end else begin
            bus_err_o <= 1'b0;
            case (state_r)
                IDLE: begin
                    tmo_cnt_r <= '0;
                    if (grant_dm_s) begin
                        state_r     <= BUSY_DM;
                        owner_dm_r  <= 1'b1;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= dm_we_i;
                        mem_sel_o   <= dm_sel_i;
                        mem_addr_o  <= dm_addr_i;
                        mem_wdata_o <= dm_wdata_i;
                        if (!if_ce_i) begin
                            starve_cnt_r <= '0;
                        end else if (starve_cnt_r < STARVE_LIM) begin
                            starve_cnt_r <= starve_cnt_r + SW'(1);
                        end else begin
                            starve_cnt_r <= starve_cnt_r;
                        end
                    end else if (grant_if_s) begin
                        state_r      <= BUSY_IF;
                        owner_dm_r   <= 1'b0;
                        mem_req_o    <= 1'b1;
                        mem_we_o     <= 1'b0;
                        mem_sel_o    <= 4'hF;
                        mem_addr_o   <= if_addr_i;
                        mem_wdata_o  <= 32'h0;
                        starve_cnt_r <= '0;
                    end else begin
                        starve_cnt_r <= '0;
                    end
                end
                BUSY_IF, BUSY_DM: begin
                    // An ack in the final watchdog cycle still wins over the abort.
                    if (mem_ack_i) begin
                        mem_req_o <= 1'b0;
                        state_r   <= DONE;
                        if (!mem_we_o) begin
                            if (owner_dm_r) begin
                                dm_rdata_o <= mem_rdata_i;
                            end else begin
                                if_data_o <= mem_rdata_i;
                            end
                        end
                    end else if (tmo_cnt_r == TMO_LAST) begin
                        mem_req_o <= 1'b0;
                        bus_err_o <= 1'b1;
                        state_r   <= DONE;
                        if (owner_dm_r) begin
                            dm_rdata_o <= 32'h0;
                        end else begin
                            if_data_o <= 32'h0;
                        end
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r   <= IDLE;
                    mem_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table plus hand sequences for
// starvation, watchdog timeout and reset during a transfer.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_ce_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        if_stall_o;
    logic        dm_ce_i;
    logic        dm_we_i;
    logic [3:0]  dm_sel_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic [31:0] dm_rdata_o;
    logic        dm_stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_sel_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;
    logic        bus_err_o;

    int n_checks = 0;
    int n_fails  = 0;

    mem_arbiter #(.STARVE_MAX(2), .TIMEOUT(5), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_stall_o(if_stall_o),
        .dm_ce_i(dm_ce_i), .dm_we_i(dm_we_i), .dm_sel_i(dm_sel_i), .dm_addr_i(dm_addr_i),
        .dm_wdata_i(dm_wdata_i), .dm_rdata_o(dm_rdata_o), .dm_stall_o(dm_stall_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_sel_o(mem_sel_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .mem_ack_i(mem_ack_i), .bus_err_o(bus_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, if_ce;
        logic [31:0] if_addr;
        logic        dm_ce, dm_we;
        logic [3:0]  dm_sel;
        logic [31:0] dm_addr, dm_wdata;
        logic        ack;
        logic [31:0] rdata;
        logic        e_if_stall, e_dm_stall, e_req, e_we;
        logic [3:0]  e_sel;
        logic [31:0] e_addr, e_wdata, e_if_data, e_dm_rdata;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        // Stall is checked before the edge, registered outputs after it.
        vecs.push_back('{1'b1,1'b1,32'h100,1'b1,1'b0,4'hF,32'h200,32'h0,1'b0,32'h0,
                         1'b1,1'b1,1'b0,1'b0,4'h0,32'h0,32'h0,32'h0,32'h0,1'b0});
        vecs.push_back('{1'b1,1'b1,32'h100,1'b1,1'b0,4'hF,32'h200,32'h0,1'b0,32'h0,
                         1'b1,1'b1,1'b0,1'b0,4'h0,32'h0,32'h0,32'h0,32'h0,1'b0});
        vecs.push_back('{1'b1,1'b1,32'h100,1'b1,1'b0,4'hF,32'h200,32'h0,1'b0,32'h0,
                         1'b1,1'b1,1'b0,1'b0,4'h0,32'h0,32'h0,32'h0,32'h0,1'b0});
        vecs.push_back('{1'b0,1'b1,32'h100,1'b1,1'b0,4'hF,32'h200,32'h0,1'b0,32'h0,
                         1'b1,1'b1,1'b1,1'b0,4'hF,32'h200,32'h0,32'h0,32'h0,1'b0});
        vecs.push_back('{1'b0,1'b0,32'h100,1'b0,1'b0,4'hF,32'h200,32'h0,1'b1,32'h11112222,
                         1'b0,1'b0,1'b0,1'b0,4'hF,32'h200,32'h0,32'h0,32'h11112222,1'b0});
        vecs.push_back('{1'b0,1'b0,32'h100,1'b0,1'b0,4'hF,32'h200,32'h0,1'b0,32'h0,
                         1'b0,1'b0,1'b0,1'b0,4'hF,32'h200,32'h0,32'h0,32'h11112222,1'b0});
        vecs.push_back('{1'b0,1'b1,32'h4,1'b0,1'b0,4'hF,32'h200,32'h0,1'b0,32'h0,
                         1'b1,1'b0,1'b1,1'b0,4'hF,32'h4,32'h0,32'h0,32'h11112222,1'b0});
        vecs.push_back('{1'b0,1'b1,32'h4,1'b0,1'b0,4'hF,32'h200,32'h0,1'b1,32'h3C011234,
                         1'b1,1'b0,1'b0,1'b0,4'hF,32'h4,32'h0,32'h3C011234,32'h11112222,1'b0});
        vecs.push_back('{1'b0,1'b1,32'h4,1'b0,1'b0,4'hF,32'h200,32'h0,1'b0,32'h0,
                         1'b0,1'b0,1'b0,1'b0,4'hF,32'h4,32'h0,32'h3C011234,32'h11112222,1'b0});
        vecs.push_back('{1'b0,1'b0,32'h4,1'b0,1'b0,4'hF,32'h200,32'h0,1'b1,32'h55555555,
                         1'b0,1'b0,1'b0,1'b0,4'hF,32'h4,32'h0,32'h3C011234,32'h11112222,1'b0});
        vecs.push_back('{1'b0,1'b0,32'h4,1'b1,1'b1,4'h3,32'h10,32'hDEADBEEF,1'b0,32'h0,
                         1'b0,1'b1,1'b1,1'b1,4'h3,32'h10,32'hDEADBEEF,32'h3C011234,32'h11112222,1'b0});
        vecs.push_back('{1'b0,1'b0,32'h4,1'b1,1'b1,4'h3,32'h10,32'hDEADBEEF,1'b0,32'h0,
                         1'b0,1'b1,1'b1,1'b1,4'h3,32'h10,32'hDEADBEEF,32'h3C011234,32'h11112222,1'b0});
        vecs.push_back('{1'b0,1'b0,32'h4,1'b1,1'b1,4'h3,32'h10,32'hDEADBEEF,1'b1,32'hFFFFFFFF,
                         1'b0,1'b1,1'b0,1'b1,4'h3,32'h10,32'hDEADBEEF,32'h3C011234,32'h11112222,1'b0});
        vecs.push_back('{1'b0,1'b0,32'h4,1'b1,1'b1,4'h3,32'h10,32'hDEADBEEF,1'b0,32'h0,
                         1'b0,1'b0,1'b0,1'b1,4'h3,32'h10,32'hDEADBEEF,32'h3C011234,32'h11112222,1'b0});
        vecs.push_back('{1'b0,1'b0,32'h4,1'b1,1'b0,4'hF,32'h10,32'h0,1'b0,32'h0,
                         1'b0,1'b1,1'b1,1'b0,4'hF,32'h10,32'h0,32'h3C011234,32'h11112222,1'b0});
        vecs.push_back('{1'b0,1'b0,32'h4,1'b1,1'b0,4'hF,32'h10,32'h0,1'b1,32'hCAFEF00D,
                         1'b0,1'b1,1'b0,1'b0,4'hF,32'h10,32'h0,32'h3C011234,32'hCAFEF00D,1'b0});
        vecs.push_back('{1'b0,1'b0,32'h4,1'b1,1'b0,4'hF,32'h10,32'h0,1'b0,32'h0,
                         1'b0,1'b0,1'b0,1'b0,4'hF,32'h10,32'h0,32'h3C011234,32'hCAFEF00D,1'b0});
        vecs.push_back('{1'b0,1'b0,32'h4,1'b0,1'b0,4'hF,32'h10,32'h0,1'b0,32'h0,
                         1'b0,1'b0,1'b0,1'b0,4'hF,32'h10,32'h0,32'h3C011234,32'hCAFEF00D,1'b0});

        rst = 1'b1; if_ce_i = 1'b0; if_addr_i = 32'h0; dm_ce_i = 1'b0; dm_we_i = 1'b0;
        dm_sel_i = 4'h0; dm_addr_i = 32'h0; dm_wdata_i = 32'h0; mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; if_ce_i = vecs[i].if_ce; if_addr_i = vecs[i].if_addr;
            dm_ce_i = vecs[i].dm_ce; dm_we_i = vecs[i].dm_we; dm_sel_i = vecs[i].dm_sel;
            dm_addr_i = vecs[i].dm_addr; dm_wdata_i = vecs[i].dm_wdata;
            mem_ack_i = vecs[i].ack; mem_rdata_i = vecs[i].rdata;
            #1;
            chk($sformatf("v%0d if_stall", i), {31'h0, if_stall_o}, {31'h0, vecs[i].e_if_stall});
            chk($sformatf("v%0d dm_stall", i), {31'h0, dm_stall_o}, {31'h0, vecs[i].e_dm_stall});
            @(negedge clk);
            chk($sformatf("v%0d mem_req", i), {31'h0, mem_req_o}, {31'h0, vecs[i].e_req});
            chk($sformatf("v%0d mem_we", i), {31'h0, mem_we_o}, {31'h0, vecs[i].e_we});
            chk($sformatf("v%0d mem_sel", i), {28'h0, mem_sel_o}, {28'h0, vecs[i].e_sel});
            chk($sformatf("v%0d mem_addr", i), mem_addr_o, vecs[i].e_addr);
            chk($sformatf("v%0d mem_wdata", i), mem_wdata_o, vecs[i].e_wdata);
            chk($sformatf("v%0d if_data", i), if_data_o, vecs[i].e_if_data);
            chk($sformatf("v%0d dm_rdata", i), dm_rdata_o, vecs[i].e_dm_rdata);
            chk($sformatf("v%0d bus_err", i), {31'h0, bus_err_o}, {31'h0, vecs[i].e_err});
        end

        // Starvation bound of 2: expected grant order DM, DM, IF, DM, DM, IF.
        begin
            logic exp_dm[6];
            exp_dm = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
            if_ce_i = 1'b1; if_addr_i = 32'h100; dm_ce_i = 1'b1; dm_we_i = 1'b0;
            dm_sel_i = 4'hF; dm_addr_i = 32'h200; mem_ack_i = 1'b0;
            for (int g = 0; g < 6; g++) begin
                @(negedge clk);
                chk($sformatf("starve g%0d req", g), {31'h0, mem_req_o}, 32'h1);
                chk($sformatf("starve g%0d addr", g), mem_addr_o, exp_dm[g] ? 32'h200 : 32'h100);
                chk($sformatf("starve g%0d busy stall", g), {30'h0, if_stall_o, dm_stall_o}, 32'h3);
                mem_ack_i = 1'b1; mem_rdata_i = 32'hA0000000 + 32'(g);
                @(negedge clk);
                mem_ack_i = 1'b0;
                chk($sformatf("starve g%0d done stall", g), {30'h0, if_stall_o, dm_stall_o},
                    exp_dm[g] ? 32'h2 : 32'h1);
                @(negedge clk);
            end
            if_ce_i = 1'b0; dm_ce_i = 1'b0;
            @(negedge clk);
        end

        // Watchdog: DM read never acknowledged; bounded by a 20-cycle budget.
        begin
            int req_cycles = 0;
            int err_cycles = 0;
            bit seen_err = 1'b0;
            dm_ce_i = 1'b1; dm_we_i = 1'b0; dm_sel_i = 4'hF; dm_addr_i = 32'h40;
            for (int c = 0; c < 20 && !seen_err; c++) begin
                @(negedge clk);
                if (mem_req_o) req_cycles++;
                if (bus_err_o) begin
                    err_cycles++;
                    seen_err = 1'b1;
                    chk("tmo dm_stall in done", {31'h0, dm_stall_o}, 32'h0);
                    chk("tmo dm_rdata zeroed", dm_rdata_o, 32'h0);
                    chk("tmo req low on abort", {31'h0, mem_req_o}, 32'h0);
                    dm_ce_i = 1'b0;
                end
            end
            chk("tmo bus_err seen", {31'h0, seen_err}, 32'h1);
            chk("tmo req cycles", 32'(req_cycles), 32'd5);
            @(negedge clk);
            if (bus_err_o) err_cycles++;
            chk("tmo bus_err pulses", 32'(err_cycles), 32'd1);
        end

        // Reset during a fetch, followed by a late ack.
        if_ce_i = 1'b1; if_addr_i = 32'h80;
        @(negedge clk);
        chk("rstmid busy req", {31'h0, mem_req_o}, 32'h1);
        rst = 1'b1; if_ce_i = 1'b0;
        @(negedge clk);
        chk("rstmid req dropped", {31'h0, mem_req_o}, 32'h0);
        rst = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'h99999999;
        @(negedge clk);
        mem_ack_i = 1'b0;
        chk("rstmid no data update", if_data_o, 32'h0);
        if_ce_i = 1'b1;
        #1;
        chk("rstmid no done stall", {31'h0, if_stall_o}, 32'h1);
        chk("rstmid no req", {31'h0, mem_req_o}, 32'h0);
        @(negedge clk);
        if_ce_i = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
